// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller for the RV32 5-stage core.
//               Resolves data-memory wait states, taken-branch flushes and
//               load-use hazards into PC / pipeline-register enables and
//               clears. Tracks a sticky memory-timeout flag and saturating
//               stall / flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter logic [1:0] LOAD_WBSEL  = 2'b00,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwen,
  input  logic [1:0]       ex_wbsel,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clear,
  output logic             idex_en,
  output logic             idex_clear,
  output logic             exmem_en,
  output logic             memwb_clear,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              lu;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              mwait;
  logic              timeout;
  logic              freeze;
  logic              err_set;

  // Hazard terms: load-use match, pending memory wait, and timeout release.
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    lu      = ex_regwen && (ex_wbsel == LOAD_WBSEL) && (ex_rd != 5'd0) &&
              (rs1_hit || rs2_hit);
    mwait   = mem_req && !mem_ready;
    timeout = (state_q == MEM_WAIT) && (wcnt_q == TIMEOUT_VAL);
    freeze  = mwait && !timeout;
    // A timeout only fires when the access is still outstanding.
    err_set = mwait && timeout;
  end

  // Pipeline controls by priority: freeze > branch flush > load-use > normal.
  // While reset is asserted the controls are forced to their pass-through values.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_clear  = 1'b0;
    idex_en     = 1'b1;
    idex_clear  = 1'b0;
    exmem_en    = 1'b1;
    memwb_clear = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        // Hold everything upstream of MEM; feed a bubble into WB.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_clear = 1'b1;
      end else if (ex_br_taken) begin
        // Squash the two wrong-path instructions in IF/ID and ID/EX.
        ifid_clear = 1'b1;
        idex_clear = 1'b1;
      end else if (lu) begin
        // Hold PC and IF/ID, load a bubble into ID/EX for one cycle.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_clear = 1'b1;
      end
    end
  end

  // Memory-wait state machine and its per-access frozen-cycle counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (mwait) begin
          state_d = MEM_WAIT;
          wcnt_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        // Completion, a dropped request, or the timeout all release the pipe.
        if (!mwait || timeout) begin
          state_d = RUN;
          wcnt_d  = 16'd0;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 16'd0;
      end
    endcase
  end

  // Sticky error flag (set beats clear) and saturating performance counters.
  always_comb begin
    mem_err_d   = err_set || (mem_err_q && !err_clr);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (ifid_clear && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios plus
//               random stimulus compared against a cycle-level reference
//               model written from the pipeline rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int T       = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // control vector order: {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_clear}
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          ex_regwen = 1'b0, ex_br_taken = 1'b0;
  logic [1:0]    ex_wbsel = 2'b11;
  logic          mem_req = 1'b0, mem_ready = 1'b0, err_clr = 1'b0;
  logic          pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_clear;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: frozen cycles so far in the current access, flag, counters
  int         m_n     = 0;
  bit         m_err   = 1'b0;
  int         m_stall = 0;
  int         m_flush = 0;
  logic [6:0] e_ctrl;
  bit         e_frz;
  bit         e_tmo;

  hazard_ctrl #(
    .LOAD_WBSEL (2'b00),
    .MEM_TIMEOUT(T),
    .CNT_W      (CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_regwen  (ex_regwen),
    .ex_wbsel   (ex_wbsel),
    .ex_br_taken(ex_br_taken),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .err_clr    (err_clr),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_clear (ifid_clear),
    .idex_en    (idex_en),
    .idex_clear (idex_clear),
    .exmem_en   (exmem_en),
    .memwb_clear(memwb_clear),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  assign ctrl = {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_clear};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n     = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Expected controls for this cycle from the current inputs and model state.
  task automatic model_comb();
    bit mw, lu_m;
    mw    = mem_req && !mem_ready;
    e_frz = mw && (m_n < T);
    e_tmo = mw && (m_n >= T);
    lu_m  = ex_regwen && (ex_wbsel == 2'b00) && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (e_frz)            e_ctrl = C_FREEZE;
    else if (ex_br_taken) e_ctrl = C_BRANCH;
    else if (lu_m)        e_ctrl = C_LU;
    else                  e_ctrl = C_NORM;
  endtask

  task automatic model_seq();
    if (e_tmo)        m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_n = e_frz ? m_n + 1 : 0;
    if (!e_ctrl[6] && m_stall < CNT_MAX) m_stall++;
    if (e_ctrl[4] && m_flush < CNT_MAX)  m_flush++;
  endtask

  // One clock with inputs already applied; optionally also checks a fixed control vector.
  task automatic cycle(input bit use_want = 1'b0, input logic [6:0] want = '0);
    #2;
    model_comb();
    check("ctrl", {25'd0, ctrl}, {25'd0, e_ctrl});
    if (use_want) check("ctrl_dir", {25'd0, ctrl}, {25'd0, want});
    @(posedge clk);
    model_seq();
    #1;
    check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
    check("stall_cnt", {28'd0, stall_cnt}, m_stall);
    check("flush_cnt", {28'd0, flush_cnt}, m_flush);
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_regwen = 0; ex_wbsel = 2'b11; ex_br_taken = 0;
    mem_req = 0; mem_ready = 0; err_clr = 0;
  endtask

  initial begin
    int ready_pct;
    idle_inputs();
    #1;
    check("reset_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    check("reset_stall", {28'd0, stall_cnt}, 0);
    check("reset_err", {31'd0, mem_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // load-use on rs1 gives one bubble
    ex_rd = 5; ex_regwen = 1; ex_wbsel = 2'b00; id_rs1 = 5; id_use_rs1 = 1;
    cycle(1'b1, C_LU);
    check("lu_stall1", {28'd0, stall_cnt}, 1);
    ex_regwen = 0;
    cycle(1'b1, C_NORM);
    // x0 never creates a hazard
    ex_rd = 0; id_rs1 = 0; ex_regwen = 1;
    cycle(1'b1, C_NORM);
    check("lu_x0", {28'd0, stall_cnt}, 1);

    // branch alone, then branch together with a load-use match
    idle_inputs();
    ex_br_taken = 1;
    cycle(1'b1, C_BRANCH);
    check("br_flush1", {28'd0, flush_cnt}, 1);
    ex_rd = 5; ex_regwen = 1; ex_wbsel = 2'b00; id_rs2 = 5; id_use_rs2 = 1;
    cycle(1'b1, C_BRANCH);
    check("br_lu_flush", {28'd0, flush_cnt}, 2);
    check("br_lu_stall", {28'd0, stall_cnt}, 1);

    // memory wait of 3 cycles with a branch held across it
    idle_inputs();
    mem_req = 1; mem_ready = 0; ex_br_taken = 1;
    for (int i = 0; i < 3; i++) cycle(1'b1, C_FREEZE);
    mem_ready = 1;
    cycle(1'b1, C_BRANCH);
    idle_inputs();
    cycle(1'b1, C_NORM);
    check("mw_stall", {28'd0, stall_cnt}, 4);
    check("mw_flush", {28'd0, flush_cnt}, 3);
    check("mw_err", {31'd0, mem_err}, 0);

    // timeout: four frozen cycles, released on the fifth
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < T; i++) cycle(1'b1, C_FREEZE);
    cycle(1'b1, C_NORM);
    check("tmo_err", {31'd0, mem_err}, 1);
    check("tmo_stall", {28'd0, stall_cnt}, 8);
    mem_req = 0; err_clr = 1;
    cycle();
    check("errclr", {31'd0, mem_err}, 0);
    // timeout coincident with err_clr: set wins
    mem_req = 1;
    for (int i = 0; i <= T; i++) cycle();
    check("tmo_clr_err", {31'd0, mem_err}, 1);
    check("tmo_clr_stall", {28'd0, stall_cnt}, 12);

    // asynchronous reset during the second frozen cycle
    err_clr = 0;
    cycle(1'b1, C_FREEZE);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    check("arst_stall", {28'd0, stall_cnt}, 0);
    check("arst_flush", {28'd0, flush_cnt}, 0);
    check("arst_err", {31'd0, mem_err}, 0);
    model_reset();
    @(posedge clk); #1;
    mem_req = 0;
    rst_n = 1'b1;
    cycle(1'b1, C_NORM);

    // saturation: 20 cycles of blocked access give 16 frozen cycles, counter stops at 15
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_stall", {28'd0, stall_cnt}, 15);
    idle_inputs();
    cycle();

    // random stimulus in phases of decreasing memory readiness
    for (int ph = 0; ph < 3; ph++) begin
      ready_pct = (ph == 0) ? 85 : (ph == 1) ? 40 : 5;
      if (ph == 1) begin
        // clear counters so saturation and counting are both exercised again
        #2; rst_n = 1'b0; #1; model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
      end
      for (int i = 0; i < 600; i++) begin
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_use_rs1  = 1'($urandom_range(0, 1));
        id_use_rs2  = 1'($urandom_range(0, 1));
        ex_rd       = 5'($urandom_range(0, 3));
        ex_regwen   = ($urandom_range(0, 99) < 80);
        ex_wbsel    = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
        ex_br_taken = ($urandom_range(0, 99) < 15);
        mem_req     = ($urandom_range(0, 99) < 40);
        mem_ready   = ($urandom_range(0, 99) < ready_pct);
        err_clr     = ($urandom_range(0, 99) < 10);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
